data_bus_responder: RTL and testbench

Responder for the CPU core's data-memory port: decodes each access on the core's `memCe`/`memWr`/`memAddr`/`wtData`/`rdData` interface and serves it. It holds a word RAM and a small MMIO register file: an 8-bit transmit FIFO drained by an external consumer, plus an optional cycle timer with compare interrupt. It sits beside the core at top level and answers loads combinationally within the same cycle, because the single-cycle MEM stage samples `rdData` immediately. Stores commit on the rising edge.

---
 rtl/data_bus_responder.sv | 178 +++++++++++++++++
 tb/tb_data_bus_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_responder.sv
// Data-memory responder: word RAM plus MMIO (TX byte FIFO, STATUS, optional timer).
// Define DBR_TIMER_EN to build the CNT/CMP cycle timer and its compare interrupt.
module data_bus_responder #(
    parameter int RAM_AW  = 10,
    parameter int FIFO_AW = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memCe,
    input  logic        memWr,
    input  logic [31:0] memAddr,
    input  logic [31:0] wtData,
    output logic [31:0] rdData,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);
    localparam int FIFO_DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

    logic [31:0]       ram_mem  [0:(1 << RAM_AW)-1];
    logic [7:0]        fifo_mem [0:FIFO_DEPTH-1];
    logic [FIFO_AW:0]  head_q, head_d, tail_q, tail_d;
    logic              ovf_q, ovf_d;

    logic              wr_s, rd_s, is_ram_s, is_mmio_s;
    logic [1:0]        sel_s;
    logic [RAM_AW-1:0] ram_idx_s;
    logic              st_tx_s, st_status_s;
    logic              full_s, empty_s, pop_s, push_s;
    logic [31:0]       cnt_rd_s, cmp_rd_s;
    logic              irq_s;
    logic              addr_unused_s;

    assign wr_s          = memCe & memWr;
    assign rd_s          = memCe & ~memWr;
    assign is_ram_s      = (memAddr[31:16] == 16'h0000);
    assign is_mmio_s     = (memAddr[31:4] == 28'h0001000);
    assign sel_s         = memAddr[3:2];
    assign ram_idx_s     = memAddr[RAM_AW+1:2];
    assign addr_unused_s = ^memAddr[1:0];
    assign st_tx_s       = wr_s & is_mmio_s & (sel_s == 2'd1);
    assign st_status_s   = wr_s & is_mmio_s & (sel_s == 2'd2);

    assign empty_s  = (head_q == tail_q);
    assign full_s   = (head_q[FIFO_AW] != tail_q[FIFO_AW]) &&
                      (head_q[FIFO_AW-1:0] == tail_q[FIFO_AW-1:0]);
    assign tx_valid = ~empty_s;
    assign pop_s    = tx_valid & tx_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign push_s   = st_tx_s & (~full_s | pop_s);
    assign irq      = irq_s;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        ovf_d  = ovf_q;
        if (pop_s) begin
            head_d = head_q + PTR_ONE;
        end else begin
            head_d = head_q;
        end
        if (push_s) begin
            tail_d = tail_q + PTR_ONE;
        end else begin
            tail_d = tail_q;
        end
        if (st_tx_s && full_s && !pop_s) begin
            ovf_d = 1'b1;
        end else if (st_status_s && wtData[3]) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            ovf_q  <= ovf_d;
        end
    end

    // Storage arrays carry no reset; the FIFO pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem[tail_q[FIFO_AW-1:0]] <= wtData[7:0];
        end
        if (wr_s && is_ram_s) begin
            ram_mem[ram_idx_s] <= wtData;
        end
    end

`ifdef DBR_TIMER_EN
    logic [31:0] cnt_q, cnt_d, cmp_q, cmp_d;
    logic        irq_q, irq_d;
    logic        st_cnt_s, st_cmp_s, irq_clr_s;

    assign st_cnt_s  = wr_s & is_mmio_s & (sel_s == 2'd0);
    assign st_cmp_s  = wr_s & is_mmio_s & (sel_s == 2'd3);
    assign irq_clr_s = (st_status_s & wtData[4]) | st_cmp_s;

    always_comb begin
        cnt_d = cnt_q + 32'd1;
        cmp_d = cmp_q;
        irq_d = irq_q;
        if (st_cnt_s) begin
            cnt_d = wtData;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
        if (st_cmp_s) begin
            cmp_d = wtData;
        end else begin
            cmp_d = cmp_q;
        end
        if (cnt_q == cmp_q) begin
            irq_d = 1'b1;
        end else if (irq_clr_s) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 32'h0;
            cmp_q <= 32'h0;
            irq_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            cmp_q <= cmp_d;
            irq_q <= irq_d;
        end
    end

    assign cnt_rd_s = cnt_q;
    assign cmp_rd_s = cmp_q;
    assign irq_s    = irq_q;
`else
    assign cnt_rd_s = 32'h0;
    assign cmp_rd_s = 32'h0;
    assign irq_s    = 1'b0;
`endif

    always_comb begin
        if (tx_valid) begin
            tx_data = fifo_mem[head_q[FIFO_AW-1:0]];
        end else begin
            tx_data = 8'h00;
        end
    end

    // Loads are answered in the same cycle; the core samples rdData without wait states.
    always_comb begin
        rdData = 32'h0;
        if (rd_s && is_ram_s) begin
            rdData = ram_mem[ram_idx_s];
        end else if (rd_s && is_mmio_s) begin
            case (sel_s)
                2'd0:    rdData = cnt_rd_s;
                2'd1:    rdData = 32'h0;
                2'd2:    rdData = {27'h0, irq_s, ovf_q, full_s, empty_s, 1'b0};
                2'd3:    rdData = cmp_rd_s;
                default: rdData = 32'h0;
            endcase
        end else begin
            rdData = 32'h0;
        end
    end
endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: directed scenarios plus random traffic against a queue-based model.
// Timer checks are compiled in when DBR_TIMER_EN is defined.
module tb_data_bus_responder;
    localparam int RAM_AW     = 10;
    localparam int FIFO_AW    = 3;
    localparam int FIFO_DEPTH = 8;
    localparam logic [31:0] A_CNT = 32'h0001_0000;
    localparam logic [31:0] A_TX  = 32'h0001_0004;
    localparam logic [31:0] A_ST  = 32'h0001_0008;
    localparam logic [31:0] A_CMP = 32'h0001_000C;
`ifdef DBR_TIMER_EN
    localparam bit          TIMER     = 1'b1;
    localparam logic [31:0] CNT_AFTER = 32'h1;
`else
    localparam bit          TIMER     = 1'b0;
    localparam logic [31:0] CNT_AFTER = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_ce = 1'b0;
    logic        mem_wr = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] wt_data = 32'h0;
    logic [31:0] rd_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_ram [int];
    logic [7:0]  m_fifo [$];
    logic        m_ovf = 1'b0;
    logic        m_irq = 1'b0;
    logic [31:0] m_cnt = 32'h0;
    logic [31:0] m_cmp = 32'h0;

    logic [31:0] obs_rd;
    logic [7:0]  obs_txd;
    logic        obs_valid;
    logic        obs_irq;

    data_bus_responder #(.RAM_AW(RAM_AW), .FIFO_AW(FIFO_AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .memCe   (mem_ce),
        .memWr   (mem_wr),
        .memAddr (mem_addr),
        .wtData  (wt_data),
        .rdData  (rd_data),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_status();
        return {27'h0, m_irq, m_ovf, (m_fifo.size() == FIFO_DEPTH), (m_fifo.size() == 0), 1'b0};
    endfunction

    function automatic logic [31:0] model_read(input logic ce, input logic wr, input logic [31:0] addr);
        logic [31:0] v;
        v = 32'h0;
        if (ce && !wr) begin
            if (addr[31:16] == 16'h0) begin
                v = m_ram[int'(addr[RAM_AW+1:2])];
            end else if (addr[31:4] == 28'h0001000) begin
                case (addr[3:2])
                    2'd0:    v = TIMER ? m_cnt : 32'h0;
                    2'd2:    v = model_status();
                    2'd3:    v = TIMER ? m_cmp : 32'h0;
                    default: v = 32'h0;
                endcase
            end
        end
        return v;
    endfunction

    task automatic model_step(input logic r, input logic ce, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wd, input logic rdy);
        logic st, mm, pop, full, irq_set, irq_clr;
        logic [1:0] sel;
        if (r) begin
            m_fifo.delete();
            m_ovf = 1'b0;
            m_cnt = 32'h0;
            m_cmp = 32'h0;
            m_irq = 1'b0;
        end else begin
            st      = ce && wr;
            mm      = (addr[31:4] == 28'h0001000);
            sel     = addr[3:2];
            pop     = (m_fifo.size() != 0) && rdy;
            full    = (m_fifo.size() == FIFO_DEPTH);
            irq_set = TIMER && (m_cnt == m_cmp);
            irq_clr = st && mm && ((sel == 2'd2 && wd[4]) || sel == 2'd3);
            if (pop) void'(m_fifo.pop_front());
            if (st && mm && sel == 2'd1) begin
                if (full && !pop) m_ovf = 1'b1;
                else m_fifo.push_back(wd[7:0]);
            end
            if (st && mm && sel == 2'd2 && wd[3]) m_ovf = 1'b0;
            if (TIMER) begin
                m_irq = irq_set || (m_irq && !irq_clr);
                m_cnt = (st && mm && sel == 2'd0) ? wd : m_cnt + 32'd1;
                if (st && mm && sel == 2'd3) m_cmp = wd;
            end
            if (st && addr[31:16] == 16'h0) m_ram[int'(addr[RAM_AW+1:2])] = wd;
        end
    endtask

    // One bus cycle: drive at negedge, check combinational outputs, then advance the model at posedge.
    task automatic do_cycle(input logic r, input logic ce, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wd, input logic rdy);
        logic [31:0] exp_rd;
        rst = r; mem_ce = ce; mem_wr = wr; mem_addr = addr; wt_data = wd; tx_ready = rdy;
        #2;
        obs_rd = rd_data; obs_txd = tx_data; obs_valid = tx_valid; obs_irq = irq;
        exp_rd = model_read(ce, wr, addr);
        if (!(ce && !wr && addr[31:16] == 16'h0 && !m_ram.exists(int'(addr[RAM_AW+1:2]))))
            check_value("rd_data", obs_rd, exp_rd);
        check_value("tx_valid", {31'h0, obs_valid}, {31'h0, (m_fifo.size() != 0)});
        if (m_fifo.size() != 0) check_value("tx_data", {24'h0, obs_txd}, {24'h0, m_fifo[0]});
        check_value("irq", {31'h0, obs_irq}, {31'h0, m_irq});
        @(posedge clk);
        model_step(r, ce, wr, addr, wd, rdy);
        @(negedge clk);
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] wd, input logic rdy);
        do_cycle(1'b0, 1'b1, 1'b1, addr, wd, rdy);
    endtask

    task automatic load(input logic [31:0] addr, input logic rdy);
        do_cycle(1'b0, 1'b1, 1'b0, addr, 32'h0, rdy);
    endtask

    task automatic idle(input logic rdy);
        do_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, rdy);
    endtask

    initial begin
        logic [31:0] a, d;
        logic [7:0]  e;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        do_cycle(1'b1, 1'b1, 1'b0, A_ST, 32'h0, 1'b0);
        check_value("rst_status", obs_rd, 32'h2);
        check_value("rst_tx_data", {24'h0, obs_txd}, 32'h0);
        check_value("rst_irq", {31'h0, obs_irq}, 32'h0);
        do_cycle(1'b1, 1'b1, 1'b0, A_CNT, 32'h0, 1'b0);
        check_value("rst_cnt", obs_rd, 32'h0);

        for (int i = 0; i < 16; i++) store({16'h0, 4'h0, 6'h0, i[3:0], 2'b00}, $urandom, 1'b0);

        // RAM and decode
        store(32'h0000_0040, 32'hDEAD_BEEF, 1'b0);
        load(32'h0000_0040, 1'b0);
        check_value("ram_rd", obs_rd, 32'hDEAD_BEEF);
        load(32'h0002_0040, 1'b0);
        check_value("unmapped_rd", obs_rd, 32'h0);
        do_cycle(1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 1'b0);
        check_value("ce_low_rd", obs_rd, 32'h0);
        load(32'h0000_F040, 1'b0);
        check_value("ram_alias", obs_rd, 32'hDEAD_BEEF);

        // FIFO fill, overflow, drain
        for (int i = 0; i < 8; i++) store(A_TX, 32'h11 + i, 1'b0);
        load(A_ST, 1'b0);
        check_value("status_full", obs_rd & 32'hF, 32'h4);
        store(A_TX, 32'h19, 1'b0);
        load(A_ST, 1'b0);
        check_value("status_ovf", obs_rd & 32'hF, 32'hC);
        for (int i = 0; i < 8; i++) begin
            idle(1'b1);
            e = 8'h11 + 8'(i);
            check_value("drain_data", {24'h0, obs_txd}, {24'h0, e});
        end
        load(A_ST, 1'b1);
        check_value("drain_empty", {31'h0, obs_valid}, 32'h0);
        check_value("status_empty_ovf", obs_rd & 32'hF, 32'hA);
        store(A_ST, 32'h8, 1'b0);
        load(A_ST, 1'b0);
        check_value("ovf_clear", obs_rd & 32'hF, 32'h2);

        // Push while full with a simultaneous pop
        for (int i = 0; i < 8; i++) store(A_TX, 32'h21 + i, 1'b0);
        store(A_TX, 32'h29, 1'b1);
        load(A_ST, 1'b0);
        check_value("full_push_pop", obs_rd & 32'hF, 32'h4);
        for (int i = 0; i < 8; i++) begin
            idle(1'b1);
            e = 8'h22 + 8'(i);
            check_value("drain2_data", {24'h0, obs_txd}, {24'h0, e});
        end

`ifdef DBR_TIMER_EN
        store(A_CMP, 32'd100, 1'b0);
        store(A_CNT, 32'd95, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            idle(1'b0);
            check_value("irq_rise", {31'h0, obs_irq}, {31'h0, (k == 7)});
        end
        load(A_ST, 1'b0);
        check_value("status_irq", obs_rd & 32'h10, 32'h10);
        store(A_ST, 32'h10, 1'b0);
        idle(1'b0);
        check_value("irq_clear", {31'h0, obs_irq}, 32'h0);
        store(A_CNT, 32'hFFFF_FFFF, 1'b0);
        idle(1'b0);
        load(A_CNT, 1'b0);
        check_value("cnt_wrap", obs_rd, 32'h0);
`endif

        // Reset with bytes queued
        for (int i = 0; i < 3; i++) store(A_TX, 32'h31 + i, 1'b0);
        do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        load(A_ST, 1'b1);
        check_value("rst_mid_valid", {31'h0, obs_valid}, 32'h0);
        check_value("rst_mid_status", obs_rd, 32'h2);
        load(A_CNT, 1'b0);
        check_value("rst_mid_cnt", obs_rd, CNT_AFTER);

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            logic r, ce, wr;
            r  = ($urandom_range(0, 99) == 0);
            ce = r ? 1'b0 : ($urandom_range(0, 3) != 0);
            wr = $urandom_range(0, 1);
            d  = $urandom;
            case ($urandom_range(0, 2))
                0: a = {16'h0, 4'($urandom_range(0, 15)), 6'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
                1: a = {28'h0001000, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
                default: a = {16'($urandom_range(2, 65535)), 16'($urandom)};
            endcase
            do_cycle(r, ce, wr, a, d, ($urandom_range(0, 2) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
